// File: rtl/k_and_s_datapath.sv
// k_and_s_datapath: datapath of the K&S multi-cycle processor.
// Holds PC, IR, instruction decoder, 4x16-bit register file, ALU and flags.
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   branch, pc_enable     PC load source (1 = IR[4:0], 0 = PC+1) and update strobe
//   ir_enable             IR <= data_in
//   write_reg_enable      register-file write strobe
//   addr_sel              ram_addr source (1 = IR[4:0], 0 = PC)
//   c_sel                 register write source (1 = ALU result, 0 = data_in)
//   operation             ALU op: 00 OR, 01 ADD, 10 SUB, 11 AND
//   flags_reg_enable      flag register update strobe
//   decoded_instruction   combinational decode of IR
//   zero_op, neg_op, unsigned_overflow, signed_overflow   registered flags
//   ram_addr, data_out    RAM address and write data (combinational)
//   data_in               RAM read data

package k_and_s_pkg;
  typedef enum logic [3:0] {
    I_NOP    = 4'd0,
    I_BRANCH = 4'd1,
    I_BZERO  = 4'd2,
    I_BNEG   = 4'd3,
    I_BOV    = 4'd4,
    I_BNZERO = 4'd5,
    I_BNNEG  = 4'd6,
    I_BNOV   = 4'd7,
    I_LOAD   = 4'd8,
    I_STORE  = 4'd9,
    I_MOVE   = 4'd10,
    I_ADD    = 4'd11,
    I_SUB    = 4'd12,
    I_AND    = 4'd13,
    I_OR     = 4'd14,
    I_HALT   = 4'd15
  } decoded_instruction_type;
endpackage

module k_and_s_datapath
  import k_and_s_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    branch,
  input  logic                    pc_enable,
  input  logic                    ir_enable,
  input  logic                    write_reg_enable,
  input  logic                    addr_sel,
  input  logic                    c_sel,
  input  logic [1:0]              operation,
  input  logic                    flags_reg_enable,
  output decoded_instruction_type decoded_instruction,
  output logic                    zero_op,
  output logic                    neg_op,
  output logic                    unsigned_overflow,
  output logic                    signed_overflow,
  output logic [4:0]              ram_addr,
  output logic [15:0]             data_out,
  input  logic [15:0]             data_in
);

  logic [4:0]  pc_q, pc_d;
  logic [15:0] ir_q;
  logic [15:0] rf_q [4];
  logic        zero_q, neg_q, uov_q, sov_q;

  decoded_instruction_type dec_s;
  logic [1:0]  dest_s;
  logic [15:0] a_s, b_s, alu_s, wdata_s;
  logic [16:0] add_s, sub_s;
  logic        uov_s, sov_s;
  logic        unused_ir_bit_s;

  // IR[7] is not part of any instruction field.
  assign unused_ir_bit_s = ir_q[7];

  // Opcode decode of IR[15:8]; unknown opcodes behave as NOP.
  always_comb begin
    case (ir_q[15:8])
      8'h00:   dec_s = I_NOP;
      8'h01:   dec_s = I_BRANCH;
      8'h02:   dec_s = I_BZERO;
      8'h03:   dec_s = I_BNEG;
      8'h04:   dec_s = I_BOV;
      8'h0A:   dec_s = I_BNZERO;
      8'h0B:   dec_s = I_BNNEG;
      8'h0C:   dec_s = I_BNOV;
      8'h81:   dec_s = I_LOAD;
      8'h82:   dec_s = I_STORE;
      8'h91:   dec_s = I_MOVE;
      8'hA1:   dec_s = I_ADD;
      8'hA2:   dec_s = I_SUB;
      8'hA3:   dec_s = I_AND;
      8'hA4:   dec_s = I_OR;
      8'hFF:   dec_s = I_HALT;
      default: dec_s = I_NOP;
    endcase
  end

  // LOAD encodes its register in IR[6:5]; everything else writes IR[5:4].
  assign dest_s = (dec_s == I_LOAD) ? ir_q[6:5] : ir_q[5:4];

  // B is zeroed for MOVE so that OR forwards A unchanged.
  assign a_s   = rf_q[ir_q[3:2]];
  assign b_s   = (dec_s == I_MOVE) ? 16'h0000 : rf_q[ir_q[1:0]];
  assign add_s = {1'b0, a_s} + {1'b0, b_s};
  // Bit 16 of the zero-extended difference is set exactly when A < B unsigned.
  assign sub_s = {1'b0, a_s} - {1'b0, b_s};

  // ALU result and overflow flags.
  always_comb begin
    case (operation)
      2'b00: begin
        alu_s = a_s | b_s;
        uov_s = 1'b0;
        sov_s = 1'b0;
      end
      2'b01: begin
        alu_s = add_s[15:0];
        uov_s = add_s[16];
        sov_s = (a_s[15] == b_s[15]) && (add_s[15] != a_s[15]);
      end
      2'b10: begin
        alu_s = sub_s[15:0];
        uov_s = sub_s[16];
        sov_s = (a_s[15] != b_s[15]) && (sub_s[15] != a_s[15]);
      end
      2'b11: begin
        alu_s = a_s & b_s;
        uov_s = 1'b0;
        sov_s = 1'b0;
      end
      default: begin
        alu_s = a_s | b_s;
        uov_s = 1'b0;
        sov_s = 1'b0;
      end
    endcase
  end

  assign wdata_s = c_sel ? alu_s : data_in;

  // PC next state: branch target or wrapping increment, both from pre-edge IR/PC.
  always_comb begin
    if (pc_enable) begin
      if (branch) begin
        pc_d = ir_q[4:0];
      end else begin
        pc_d = pc_q + 5'd1;
      end
    end else begin
      pc_d = pc_q;
    end
  end

  // PC and IR registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= 5'd0;
      ir_q <= 16'h0000;
    end else begin
      pc_q <= pc_d;
      if (ir_enable) begin
        ir_q <= data_in;
      end
    end
  end

  // Register file; sources read the old value when dest equals a source.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        rf_q[i] <= 16'h0000;
      end
    end else if (write_reg_enable) begin
      rf_q[dest_s] <= wdata_s;
    end
  end

  // Flag registers, captured from the same ALU result as a concurrent write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
      uov_q  <= 1'b0;
      sov_q  <= 1'b0;
    end else if (flags_reg_enable) begin
      zero_q <= (alu_s == 16'h0000);
      neg_q  <= alu_s[15];
      uov_q  <= uov_s;
      sov_q  <= sov_s;
    end
  end

  assign decoded_instruction = dec_s;
  assign ram_addr            = addr_sel ? ir_q[4:0] : pc_q;
  assign data_out            = rf_q[ir_q[6:5]];
  assign zero_op             = zero_q;
  assign neg_op              = neg_q;
  assign unsigned_overflow   = uov_q;
  assign signed_overflow     = sov_q;

endmodule

// File: doc/k_and_s_datapath.md
# k_and_s_datapath

Datapath for the K&S multi-cycle processor. It holds the program counter, the instruction register, the instruction decoder, a 4×16-bit register file, the ALU and the flag registers. It executes the control word issued by the control unit each cycle and returns the decoded instruction and registered flags to it. It drives the address and write data to the shared single-port RAM and samples read data from it.

## Interface
- No parameters. Data width is 16 bits; RAM address width is 5 bits, giving 32 words.
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- branch  input  1  PC load source: 1 = branch target, 0 = PC+1.
- pc_enable  input  1  PC update strobe.
- ir_enable  input  1  IR load strobe (IR <= data_in).
- write_reg_enable  input  1  register-file write strobe.
- addr_sel  input  1  ram_addr source: 1 = IR[4:0], 0 = PC.
- c_sel  input  1  register write source: 1 = ALU result, 0 = data_in.
- operation  input  2  ALU operation: 00 OR, 01 ADD, 10 SUB, 11 AND.
- flags_reg_enable  input  1  flag register update strobe.
- decoded_instruction  output  decoded_instruction_type  combinational decode of IR.
- zero_op, neg_op, unsigned_overflow, signed_overflow  output  1 each  registered flags.
- ram_addr  output  5  RAM address (combinational).
- data_out  output  16  RAM write data = R[IR[6:5]] (combinational).
- data_in  input  16  RAM read data.

## Operation
- **Instruction encoding:**
  - Opcode is IR[15:8].
  - ALU and move instructions: destination C = IR[5:4], operand A = IR[3:2], operand B = IR[1:0].
  - Load and store: register = IR[6:5], memory address = IR[4:0].
  - Branches: target = IR[4:0].
- **Opcode decode (IR[15:8]):**
  - 0x00 I_NOP, 0x01 I_BRANCH, 0x02 I_BZERO, 0x03 I_BNEG, 0x04 I_BOV, 0x0A I_BNZERO, 0x0B I_BNNEG, 0x0C I_BNOV.
  - 0x81 I_LOAD, 0x82 I_STORE, 0x91 I_MOVE.
  - 0xA1 I_ADD, 0xA2 I_SUB, 0xA3 I_AND, 0xA4 I_OR.
  - 0xFF I_HALT; any other value decodes to I_NOP.
- **PC:** 5-bit register.
  - pc_enable=1, branch=1: PC <= IR[4:0].
  - pc_enable=1, branch=0: PC <= PC+1, wrapping from 31 to 0.
- **IR:** IR <= data_in when ir_enable=1.
- **Register file:** on write_reg_enable=1, R[dest] <= (c_sel ? alu_result : data_in).
  - dest = IR[6:5] when decoded_instruction is I_LOAD, otherwise IR[5:4].
  - Writes to any of R0–R3 are legal; no register is hard-wired to zero.
- **ALU operands:** A = R[IR[3:2]]; B = R[IR[1:0]], forced to 0 for I_MOVE so that OR passes A through.
- **ALU result (16 bits, modulo 2^16):**
  - ADD: A+B.
  - SUB: A−B.
  - AND: A&B.
  - OR: A|B.
- **Flags:** captured on flags_reg_enable=1, otherwise held.
  - zero = (result == 0).
  - neg = result[15].
  - unsigned_overflow: carry-out for ADD, borrow (A < B unsigned) for SUB, 0 for AND/OR.
  - signed_overflow: two's-complement overflow for ADD/SUB, 0 for AND/OR.
- **Simultaneous strobes:**
  - ir_enable and pc_enable in the same cycle: both registers update. The PC increment and the branch target both use the pre-edge IR.
  - write_reg_enable and flags_reg_enable in the same cycle: the same ALU result is used for both.
  - A destination equal to a source register reads the old value; the write takes effect at the edge.

## Timing
- **Reset (asynchronous):** on rst_n low, PC, IR, all four registers and all four flags go to 0 immediately. Consequently decoded_instruction = I_NOP, ram_addr = 0 and data_out = 0. Reset asserted mid-instruction discards all state.
- **Register updates:** every register updates on the rising clk edge only when its strobe is high.
- **Combinational outputs:** ram_addr, data_out, decoded_instruction and the ALU result are combinational from the current state, with zero-cycle latency.
- **RAM read latency:** the RAM has a 1-cycle synchronous read. The datapath samples data_in in the cycle the strobe is high; it applies no alignment of its own.
- **Control sequence (one pass per instruction):**
  - Fetch cycle: addr_sel=0.
  - IR-load cycle: ir_enable and pc_enable.
  - Decode cycle: flags must already be valid for conditional branches.
  - Execute cycle: LOAD, STORE, ALU or BRANCH.

## Test plan
- **Reset:** hold rst_n=0 for 3 cycles with random inputs → all outputs 0, decoded_instruction=I_NOP. Assert rst_n low mid-ADD → R and flags clear without waiting for a clock edge.
- **Fetch:** data_in=0x8105, ir_enable=pc_enable=1 from reset → decoded_instruction=I_LOAD, PC=1. Then ram_addr=1 with addr_sel=0 and ram_addr=5 with addr_sel=1.
- **Load and ADD:**
  - Load R2=0x7FFF and R3=0x0001 (c_sel=0, write_reg_enable).
  - Load IR=0xA11B, operation=01, c_sel=1, write and flag strobes high.
  - Expect R1=0x8000, neg=1, zero=0, signed_overflow=1, unsigned_overflow=0.
- **SUB:**
  - R2=R3=5, SUB (0xA21B, op=10) → R1=0, zero=1, borrow=0.
  - R2=0, R3=1 → R1=0xFFFF, neg=1, unsigned_overflow=1, signed_overflow=0.
- **Branch, PC wrap and strobe gating:**
  - IR=0x0114, branch=1, pc_enable=1 → PC=0x14.
  - PC=31, pc_enable=1, branch=0 → PC=0.
  - All strobes low → no register changes.
- **Store and MOVE:**
  - IR=0x8247, R2=0xBEEF, addr_sel=1 → ram_addr=7, data_out=0xBEEF.
  - MOVE 0x9108 (R0 ← R2) with op=00 → R0=0xBEEF, neg=1.
